// File: rtl/maquina_cafe_param.sv
// maquina_cafe_param: parametrised coffee-machine controller.
// Latches a validated drink selection, prices it, collects coins, returns
// change or refunds, times preparation by size and holds "listo" until the
// cup is collected.
// Optional feature: define PAGO_TIMEOUT_EN so that a payment with no accepted
// coin for T_TIMEOUT cycles is refunded and aborted, as on cancelar.
module maquina_cafe_param #(
  parameter int unsigned N_TIPOS     = 4,
  parameter int unsigned N_TAMANOS   = 3,
  parameter int unsigned MAX_AZUCAR  = 5,
  parameter int unsigned W_PRECIO    = 12,
  parameter int unsigned PRECIO_BASE = 500,
  parameter int unsigned PASO_TIPO   = 250,
  parameter int unsigned PASO_TAMANO = 500,
  parameter int unsigned T_BASE      = 4,
  parameter int unsigned T_PASO      = 2,
  parameter int unsigned T_TIMEOUT   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          tipo_cafe_in,
  input  logic [1:0]          tamano_in,
  input  logic [2:0]          nivel_azucar_in,
  input  logic                validar,
  input  logic                moneda_valida,
  input  logic [W_PRECIO-1:0] moneda_valor,
  input  logic                cancelar,
  input  logic                retirar,
  output logic [W_PRECIO-1:0] precio,
  output logic [W_PRECIO-1:0] credito,
  output logic [W_PRECIO-1:0] cambio,
  output logic                cambio_valido,
  output logic                moneda_rechazada,
  output logic                SELECCION_valida,
  output logic                error_seleccion,
  output logic                concentracion,
  output logic                leche,
  output logic                espuma,
  output logic [2:0]          azucar_anadido,
  output logic                preparando,
  output logic                listo
);

  typedef enum logic [1:0] {IDLE, PAGO, PREP, LISTO} t_estado;

  // Longest preparation; the down-counter only ever holds T-1.
  localparam int unsigned T_MAX = T_BASE + (N_TAMANOS - 1) * T_PASO;
  localparam int unsigned W_CNT = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [W_PRECIO-1:0] P_BASE = W_PRECIO'(PRECIO_BASE);
  localparam logic [W_PRECIO-1:0] P_TIPO = W_PRECIO'(PASO_TIPO);
  localparam logic [W_PRECIO-1:0] P_TAM  = W_PRECIO'(PASO_TAMANO);

  t_estado             r_state, w_state_next;
  logic [2:0]          r_tipo, w_tipo_next;
  logic [1:0]          r_tamano, w_tamano_next;
  logic [2:0]          r_azucar, w_azucar_next;
  logic [W_PRECIO-1:0] r_precio, w_precio_next;
  logic [W_PRECIO-1:0] r_credito, w_credito_next;
  logic [W_PRECIO-1:0] r_cambio, w_cambio_next;
  logic                r_cambio_valido, w_cambio_valido_next;
  logic                r_rechazo, w_rechazo_next;
  logic                r_error, w_error_next;
  logic                r_sel, w_sel_next;
  logic [W_CNT-1:0]    r_cnt, w_cnt_next;

`ifdef PAGO_TIMEOUT_EN
  localparam int unsigned W_TO = (T_TIMEOUT > 1) ? $clog2(T_TIMEOUT) : 1;
  logic [W_TO-1:0]     r_to_cnt, w_to_cnt_next;
`endif

  logic                w_sel_ok;
  logic [W_PRECIO-1:0] w_precio_calc;
  logic [W_PRECIO:0]   w_suma;
  logic [W_CNT-1:0]    w_tprep;
  logic                w_activo;

  assign w_sel_ok = (32'(tipo_cafe_in) < N_TIPOS) &&
                    (32'(tamano_in) < N_TAMANOS) &&
                    (32'(nivel_azucar_in) <= MAX_AZUCAR);

  // Price wraps at W_PRECIO bits by construction.
  assign w_precio_calc = P_BASE + W_PRECIO'(tipo_cafe_in) * P_TIPO
                                + W_PRECIO'(tamano_in) * P_TAM;

  // One extra bit exposes a coin that would overflow the credit register.
  assign w_suma  = {1'b0, r_credito} + {1'b0, moneda_valor};
  assign w_tprep = W_CNT'(T_BASE + 32'(r_tamano) * T_PASO - 1);

  // Next-state and next-register logic for the whole controller.
  always_comb begin
    w_state_next         = r_state;
    w_tipo_next          = r_tipo;
    w_tamano_next        = r_tamano;
    w_azucar_next        = r_azucar;
    w_precio_next        = r_precio;
    w_credito_next       = r_credito;
    w_cambio_next        = r_cambio;
    w_cambio_valido_next = 1'b0;
    w_rechazo_next       = moneda_valida;  // any coin not explicitly accepted
    w_error_next         = 1'b0;
    w_sel_next           = r_sel;
    w_cnt_next           = r_cnt;
`ifdef PAGO_TIMEOUT_EN
    w_to_cnt_next        = r_to_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (validar) begin
          if (w_sel_ok) begin
            w_tipo_next    = tipo_cafe_in;
            w_tamano_next  = tamano_in;
            w_azucar_next  = nivel_azucar_in;
            w_precio_next  = w_precio_calc;
            w_credito_next = '0;
            w_sel_next     = 1'b1;
            w_state_next   = PAGO;
`ifdef PAGO_TIMEOUT_EN
            w_to_cnt_next  = '0;
`endif
          end else begin
            w_error_next = 1'b1;
          end
        end
      end
      PAGO: begin
        if (cancelar) begin
          // Refund wins over a coin arriving in the same cycle.
          w_cambio_next        = r_credito;
          w_cambio_valido_next = 1'b1;
          w_credito_next       = '0;
          w_sel_next           = 1'b0;
          w_state_next         = IDLE;
        end else if (r_credito >= r_precio) begin
          w_cambio_next        = r_credito - r_precio;
          w_cambio_valido_next = 1'b1;
          w_credito_next       = '0;
          w_cnt_next           = w_tprep;
          w_state_next         = PREP;
        end else if (moneda_valida && !w_suma[W_PRECIO]) begin
          w_credito_next = w_suma[W_PRECIO-1:0];
          w_rechazo_next = 1'b0;
`ifdef PAGO_TIMEOUT_EN
          w_to_cnt_next  = '0;
        end else if (r_to_cnt == W_TO'(T_TIMEOUT - 1)) begin
          w_cambio_next        = r_credito;
          w_cambio_valido_next = 1'b1;
          w_credito_next       = '0;
          w_sel_next           = 1'b0;
          w_state_next         = IDLE;
        end else begin
          w_to_cnt_next = r_to_cnt + 1'b1;
`endif
        end
      end
      PREP: begin
        if (r_cnt == '0) begin
          w_state_next = LISTO;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      LISTO: begin
        if (retirar) begin
          w_sel_next    = 1'b0;
          w_tipo_next   = '0;
          w_tamano_next = '0;
          w_azucar_next = '0;
          w_state_next  = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset drops everything with no refund.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_tipo          <= '0;
      r_tamano        <= '0;
      r_azucar        <= '0;
      r_precio        <= '0;
      r_credito       <= '0;
      r_cambio        <= '0;
      r_cambio_valido <= 1'b0;
      r_rechazo       <= 1'b0;
      r_error         <= 1'b0;
      r_sel           <= 1'b0;
      r_cnt           <= '0;
`ifdef PAGO_TIMEOUT_EN
      r_to_cnt        <= '0;
`endif
    end else begin
      r_state         <= w_state_next;
      r_tipo          <= w_tipo_next;
      r_tamano        <= w_tamano_next;
      r_azucar        <= w_azucar_next;
      r_precio        <= w_precio_next;
      r_credito       <= w_credito_next;
      r_cambio        <= w_cambio_next;
      r_cambio_valido <= w_cambio_valido_next;
      r_rechazo       <= w_rechazo_next;
      r_error         <= w_error_next;
      r_sel           <= w_sel_next;
      r_cnt           <= w_cnt_next;
`ifdef PAGO_TIMEOUT_EN
      r_to_cnt        <= w_to_cnt_next;
`endif
    end
  end

  // Dispenser attributes are live from PREP entry until LISTO is left.
  assign w_activo = (r_state == PREP) || (r_state == LISTO);

  assign precio           = r_precio;
  assign credito          = r_credito;
  assign cambio           = r_cambio;
  assign cambio_valido    = r_cambio_valido;
  assign moneda_rechazada = r_rechazo;
  assign error_seleccion  = r_error;
  assign SELECCION_valida = r_sel;
  assign leche            = w_activo & r_tipo[0];
  assign concentracion    = w_activo & r_tipo[1];
  assign espuma           = w_activo & (r_tipo == 3'd3);
  assign azucar_anadido   = w_activo ? r_azucar : 3'd0;
  assign preparando       = (r_state == PREP);
  assign listo            = (r_state == LISTO);

endmodule

// File: tb/tb_maquina_cafe_param.sv
// Scoreboard bench for maquina_cafe_param: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_maquina_cafe_param;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [2:0]   tipo_cafe_in = '0;
  logic [1:0]   tamano_in = '0;
  logic [2:0]   nivel_azucar_in = '0;
  logic         validar = 1'b0;
  logic         moneda_valida = 1'b0;
  logic [W-1:0] moneda_valor = '0;
  logic         cancelar = 1'b0;
  logic         retirar = 1'b0;
  logic [W-1:0] precio, credito, cambio;
  logic         cambio_valido, moneda_rechazada, SELECCION_valida, error_seleccion;
  logic         concentracion, leche, espuma, preparando, listo;
  logic [2:0]   azucar_anadido;

  maquina_cafe_param dut (
    .clk(clk), .reset(reset),
    .tipo_cafe_in(tipo_cafe_in), .tamano_in(tamano_in), .nivel_azucar_in(nivel_azucar_in),
    .validar(validar), .moneda_valida(moneda_valida), .moneda_valor(moneda_valor),
    .cancelar(cancelar), .retirar(retirar),
    .precio(precio), .credito(credito), .cambio(cambio), .cambio_valido(cambio_valido),
    .moneda_rechazada(moneda_rechazada), .SELECCION_valida(SELECCION_valida),
    .error_seleccion(error_seleccion), .concentracion(concentracion), .leche(leche),
    .espuma(espuma), .azucar_anadido(azucar_anadido), .preparando(preparando), .listo(listo)
  );

  always #5 clk = ~clk;

  typedef struct { int len; int le; int co; int es; int az; } prep_t;

  int    total = 0;
  int    bad = 0;
  int    q_cambio[$];   // expected change amounts, in order
  int    q_precio[$];   // expected price at each new selection
  int    q_rech[$];     // expected credito when a coin is rejected
  int    q_err[$];      // expected SELECCION_valida on error pulse
  prep_t q_prep[$];     // expected preparation records

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  // Monitor: compares each DUT output event against the scoreboard.
  initial begin
    logic  sel_prev;
    logic  prep_prev;
    int    prep_len;
    int    prep_exp;
    prep_t p;
    sel_prev = 1'b0; prep_prev = 1'b0; prep_len = 0; prep_exp = 0;
    forever begin
      @(negedge clk);
      if (cambio_valido) begin
        if (q_cambio.size() == 0) chk("cambio_extra", int'(cambio_valido), 0);
        else chk("cambio", int'(cambio), q_cambio.pop_front());
      end
      if (moneda_rechazada) begin
        if (q_rech.size() == 0) chk("rech_extra", int'(moneda_rechazada), 0);
        else chk("rech_credito", int'(credito), q_rech.pop_front());
      end
      if (error_seleccion) begin
        if (q_err.size() == 0) chk("err_extra", int'(error_seleccion), 0);
        else chk("err_sel_valida", int'(SELECCION_valida), q_err.pop_front());
      end
      if (SELECCION_valida && !sel_prev) begin
        if (q_precio.size() == 0) chk("sel_extra", int'(SELECCION_valida), 0);
        else chk("precio", int'(precio), q_precio.pop_front());
      end
      if (preparando && !prep_prev) begin
        if (q_prep.size() == 0) begin
          chk("prep_extra", int'(preparando), 0);
          prep_exp = 0;
        end else begin
          p = q_prep.pop_front();
          prep_exp = p.len;
          chk("leche", int'(leche), p.le);
          chk("concentracion", int'(concentracion), p.co);
          chk("espuma", int'(espuma), p.es);
          chk("azucar", int'(azucar_anadido), p.az);
        end
        prep_len = 1;
      end else if (preparando) begin
        prep_len++;
      end else if (prep_prev && reset) begin
        chk("prep_len", prep_len, prep_exp);
        chk("listo_tras_prep", int'(listo), 1);
      end
      prep_prev = preparando;
      sel_prev  = SELECCION_valida;
    end
  end

  // Each stimulus task starts at a negedge and consumes one clock cycle.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic seleccion(input int t, input int s, input int a);
    tipo_cafe_in = 3'(t); tamano_in = 2'(s); nivel_azucar_in = 3'(a); validar = 1'b1;
    @(negedge clk);
    validar = 1'b0;
  endtask

  task automatic moneda(input int v);
    moneda_valida = 1'b1; moneda_valor = W'(v);
    @(negedge clk);
    moneda_valida = 1'b0;
  endtask

  task automatic pulso_cancelar();
    cancelar = 1'b1;
    @(negedge clk);
    cancelar = 1'b0;
  endtask

  task automatic pulso_retirar();
    retirar = 1'b1;
    @(negedge clk);
    retirar = 1'b0;
  endtask

  task automatic push_prep(input int len, input int le, input int co, input int es, input int az);
    prep_t p;
    p.len = len; p.le = le; p.co = co; p.es = es; p.az = az;
    q_prep.push_back(p);
  endtask

  task automatic wait_listo();
    int n;
    n = 0;
    while (!listo && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_listo", int'(listo), 1);
  endtask

  task automatic wait_prep();
    int n;
    n = 0;
    while (!preparando && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_prep", int'(preparando), 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_precio", int'(precio), 0);
    chk("rst_credito", int'(credito), 0);
    chk("rst_cambio_valido", int'(cambio_valido), 0);
    chk("rst_sel", int'(SELECCION_valida), 0);
    chk("rst_preparando", int'(preparando), 0);
    chk("rst_listo", int'(listo), 0);
    reset = 1'b1;
    tick();

    // Cheapest drink, exact payment, zero change
    q_precio.push_back(500);
    seleccion(0, 0, 0);
    q_cambio.push_back(0);
    push_prep(4, 0, 0, 0, 0);
    moneda(500);
    wait_listo();
    pulso_retirar();
    chk("t2_listo_off", int'(listo), 0);

    // Most expensive drink, three coins, change 250, listo held
    q_precio.push_back(2250);
    seleccion(3, 2, 5);
    moneda(1000);
    moneda(1000);
    q_cambio.push_back(250);
    push_prep(8, 1, 1, 1, 5);
    moneda(500);
    wait_listo();
    repeat (5) tick();
    chk("t3_listo_hold", int'(listo), 1);
    chk("t3_espuma_listo", int'(espuma), 1);
    chk("t3_azucar_listo", int'(azucar_anadido), 5);
    pulso_retirar();
    chk("t3_listo_off", int'(listo), 0);
    chk("t3_sel_off", int'(SELECCION_valida), 0);
    chk("t3_leche_off", int'(leche), 0);
    chk("t3_azucar_off", int'(azucar_anadido), 0);

    // Reset asserted mid-preparation clears outputs asynchronously
    q_precio.push_back(500);
    seleccion(0, 0, 0);
    q_cambio.push_back(0);
    push_prep(4, 0, 0, 0, 0);
    moneda(500);
    wait_prep();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t1_preparando", int'(preparando), 0);
    chk("t1_sel", int'(SELECCION_valida), 0);
    chk("t1_precio", int'(precio), 0);
    chk("t1_credito", int'(credito), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("t1_idle_prep", int'(preparando), 0);
    chk("t1_idle_listo", int'(listo), 0);

    // Invalid size, cancel in IDLE ignored, coin in IDLE rejected
    q_err.push_back(0);
    seleccion(1, 3, 0);
    chk("t4_sel", int'(SELECCION_valida), 0);
    pulso_cancelar();
    q_rech.push_back(0);
    moneda(100);
    tick();

    // Cancel with a simultaneous coin; validar in PAGO ignored
    q_precio.push_back(1500);
    seleccion(2, 1, 0);
    moneda(500);
    seleccion(0, 0, 0);
    chk("t5_precio_kept", int'(precio), 1500);
    q_cambio.push_back(500);
    q_rech.push_back(0);
    cancelar = 1'b1; moneda_valida = 1'b1; moneda_valor = W'(250);
    @(negedge clk);
    cancelar = 1'b0; moneda_valida = 1'b0;
    tick();
    chk("t5_sel", int'(SELECCION_valida), 0);
    chk("t5_credito", int'(credito), 0);

    // Coin that would overflow the credit register is rejected
    q_precio.push_back(2250);
    seleccion(3, 2, 0);
    moneda(2000);
    q_rech.push_back(2000);
    moneda(4000);
    chk("t7_credito", int'(credito), 2000);
    q_cambio.push_back(0);
    push_prep(8, 1, 1, 1, 0);
    moneda(250);
    wait_listo();
    pulso_retirar();

    // Idle payment: refunded by timeout, or waits until cancelled
    q_precio.push_back(1250);
    seleccion(1, 1, 0);
    moneda(250);
`ifdef PAGO_TIMEOUT_EN
    q_cambio.push_back(250);
    repeat (40) tick();
    chk("t6_sel", int'(SELECCION_valida), 0);
`else
    repeat (40) tick();
    chk("t6_sel_wait", int'(SELECCION_valida), 1);
    chk("t6_credito", int'(credito), 250);
    q_cambio.push_back(250);
    pulso_cancelar();
    tick();
    chk("t6_sel", int'(SELECCION_valida), 0);
`endif

    repeat (3) tick();
    chk("q_cambio_left", q_cambio.size(), 0);
    chk("q_precio_left", q_precio.size(), 0);
    chk("q_rech_left", q_rech.size(), 0);
    chk("q_err_left", q_err.size(), 0);
    chk("q_prep_left", q_prep.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
